// File: rtl/memory_pkg.sv
// Request-field layout, access codes and FSM encoding shared by the memory responder blocks.
package memory_pkg;

    localparam int unsigned REQ_WIDTH    = 33;
    localparam int unsigned REQ_RW_BIT   = 32;
    localparam int unsigned REQ_DATA_MSB = 31;
    localparam int unsigned REQ_DATA_LSB = 16;
    localparam int unsigned REQ_ADDR_MSB = 15;
    localparam int unsigned REQ_ADDR_LSB = 0;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2,
        StRelease = 2'd3
    } state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter; release flags keep a still-held, already served request
// from being granted again until its cache drops request_ready.
module memory_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic grant_enable,
    input  logic request_ready_0,
    input  logic request_ready_1,
    input  logic release_set,
    input  logic release_port,
    output logic grant_valid,
    output logic grant_port
);

    logic       pointer_q, pointer_d;
    logic [1:0] release_q, release_d;
    logic [1:0] eligible;

    always_comb begin
        eligible    = {request_ready_1 & ~release_q[1], request_ready_0 & ~release_q[0]};
        grant_valid = grant_enable & (|eligible);
        grant_port  = 1'b0;
        pointer_d   = pointer_q;

        if (eligible == 2'b11) begin
            grant_port = pointer_q;
            if (grant_enable) begin
                pointer_d = ~pointer_q;
            end
        end else begin
            grant_port = eligible[1];
        end

        release_d = release_q;
        if (!request_ready_0) begin
            release_d[0] = 1'b0;
        end
        if (!request_ready_1) begin
            release_d[1] = 1'b0;
        end
        // Setting wins: the served cache is still holding ready in this cycle.
        if (release_set) begin
            release_d[release_port] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pointer_q <= 1'b0;
            release_q <= 2'b00;
        end else begin
            pointer_q <= pointer_d;
            release_q <= release_d;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory side of the cache/memory protocol: arbitrates two ports and serves a 16-bit word array.
// Invalidate broadcast to the non-writing cache is built only when MEMORY_INVALIDATE_EN is defined.
module memory_responder
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_WORD_BITS = 8,
    parameter int unsigned ACCESS_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [32:0] memory_request_0,
    input  logic        memory_request_ready_0,
    input  logic [32:0] memory_request_1,
    input  logic        memory_request_ready_1,
    output logic [15:0] memory_response_0,
    output logic        memory_response_ready_0,
    output logic [15:0] memory_response_1,
    output logic        memory_response_ready_1,
    output logic [15:0] invalidate_address_0,
    output logic        invalidate_valid_0,
    output logic [15:0] invalidate_address_1,
    output logic        invalidate_valid_1
);

    localparam int unsigned DEPTH      = 2 ** ADDR_WORD_BITS;
    localparam logic [3:0]  LOAD_COUNT = 4'(ACCESS_LATENCY - 1);

    state_t                    state_q, state_d;
    logic [REQ_WIDTH-1:0]      hold_q;
    logic                      hold_port_q;
    logic [3:0]                count_q;
    logic                      access_first_q;
    logic                      grant_valid;
    logic                      grant_port;

    logic [15:0]               mem [DEPTH];
    logic [ADDR_WORD_BITS-1:0] word_index;
    logic                      hold_write;
    logic [15:0]               hold_data;
    logic [15:0]               read_data;
    logic [15:0]               response_word;

    logic [15:0]               response_0_q, response_1_q;
    logic                      response_ready_0_q, response_ready_1_q;

    memory_arbiter u_arbiter (
        .clock           (clock),
        .reset           (reset),
        .grant_enable    (state_q == StIdle),
        .request_ready_0 (memory_request_ready_0),
        .request_ready_1 (memory_request_ready_1),
        .release_set     (state_q == StRespond),
        .release_port    (hold_port_q),
        .grant_valid     (grant_valid),
        .grant_port      (grant_port)
    );

    // Address bit 0 selects a byte within the word and bits above the index alias.
    assign word_index    = hold_q[REQ_ADDR_LSB+ADDR_WORD_BITS:REQ_ADDR_LSB+1];
    assign hold_write    = (hold_q[REQ_RW_BIT] == WRITE);
    assign hold_data     = hold_q[REQ_DATA_MSB:REQ_DATA_LSB];
    assign read_data     = mem[word_index];
    assign response_word = (hold_q[REQ_RW_BIT] == READ) ? read_data : hold_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (grant_valid) state_d = StAccess;
            StAccess:  if (count_q == 4'd0) state_d = StRespond;
            StRespond: state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            hold_q         <= '0;
            hold_port_q    <= 1'b0;
            count_q        <= 4'd0;
            access_first_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            access_first_q <= 1'b0;
            if (state_q == StIdle && grant_valid) begin
                hold_q         <= grant_port ? memory_request_1 : memory_request_0;
                hold_port_q    <= grant_port;
                count_q        <= LOAD_COUNT;
                access_first_q <= 1'b1;
            end else if (state_q == StAccess && count_q != 4'd0) begin
                count_q <= count_q - 4'd1;
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clock) begin
        if (state_q == StAccess && access_first_q && hold_write) begin
            mem[word_index] <= hold_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            response_0_q       <= '0;
            response_1_q       <= '0;
            response_ready_0_q <= 1'b0;
            response_ready_1_q <= 1'b0;
        end else begin
            response_ready_0_q <= 1'b0;
            response_ready_1_q <= 1'b0;
            if (state_q == StRespond) begin
                if (hold_port_q) begin
                    response_1_q       <= response_word;
                    response_ready_1_q <= 1'b1;
                end else begin
                    response_0_q       <= response_word;
                    response_ready_0_q <= 1'b1;
                end
            end
        end
    end

    assign memory_response_0       = response_0_q;
    assign memory_response_1       = response_1_q;
    assign memory_response_ready_0 = response_ready_0_q;
    assign memory_response_ready_1 = response_ready_1_q;

`ifdef MEMORY_INVALIDATE_EN
    logic [15:0] hold_addr;
    logic [15:0] inv_addr_0_q, inv_addr_1_q;
    logic        inv_valid_0_q, inv_valid_1_q;

    assign hold_addr = hold_q[REQ_ADDR_MSB:REQ_ADDR_LSB];

    // The writer's own cache already holds the new data, so only the other port is told.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inv_addr_0_q  <= '0;
            inv_addr_1_q  <= '0;
            inv_valid_0_q <= 1'b0;
            inv_valid_1_q <= 1'b0;
        end else begin
            inv_valid_0_q <= 1'b0;
            inv_valid_1_q <= 1'b0;
            if (state_q == StRespond && hold_write) begin
                if (hold_port_q) begin
                    inv_addr_0_q  <= hold_addr;
                    inv_valid_0_q <= 1'b1;
                end else begin
                    inv_addr_1_q  <= hold_addr;
                    inv_valid_1_q <= 1'b1;
                end
            end
        end
    end

    assign invalidate_address_0 = inv_addr_0_q;
    assign invalidate_address_1 = inv_addr_1_q;
    assign invalidate_valid_0   = inv_valid_0_q;
    assign invalidate_valid_1   = inv_valid_1_q;
`else
    logic unused_hold_addr;
    assign unused_hold_addr     = ^hold_q[REQ_ADDR_MSB:REQ_ADDR_LSB];

    assign invalidate_address_0 = '0;
    assign invalidate_address_1 = '0;
    assign invalidate_valid_0   = 1'b0;
    assign invalidate_valid_1   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed plus randomized checks of memory_responder against an array/queue reference model.
module tb_memory_responder;
    import memory_pkg::*;

    localparam int unsigned AWB = 8;
    localparam int unsigned LAT = 2;
    // Negedges from driving a request (responder idle) until its pulse is visible.
    localparam int SINGLE_WAIT = LAT + 2;
    // Cycles one transaction occupies: idle grant, access, respond, release.
    localparam int SLOT = LAT + 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [32:0] memory_request_0, memory_request_1;
    logic        memory_request_ready_0, memory_request_ready_1;
    logic [15:0] memory_response_0, memory_response_1;
    logic        memory_response_ready_0, memory_response_ready_1;
    logic [15:0] invalidate_address_0, invalidate_address_1;
    logic        invalidate_valid_0, invalidate_valid_1;

    memory_responder #(
        .ADDR_WORD_BITS (AWB),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .memory_request_0        (memory_request_0),
        .memory_request_ready_0  (memory_request_ready_0),
        .memory_request_1        (memory_request_1),
        .memory_request_ready_1  (memory_request_ready_1),
        .memory_response_0       (memory_response_0),
        .memory_response_ready_0 (memory_response_ready_0),
        .memory_response_1       (memory_response_1),
        .memory_response_ready_1 (memory_response_ready_1),
        .invalidate_address_0    (invalidate_address_0),
        .invalidate_valid_0      (invalidate_valid_0),
        .invalidate_address_1    (invalidate_address_1),
        .invalidate_valid_1      (invalidate_valid_1)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [int];
    int          written_idx [$];
    int          rr_ptr = 0;

    int          last_lat;
    logic [15:0] last_data;
    logic        last_width_ok;
    int          other_pulses;
    int          inv_other_hits;
    int          inv_self_hits;
    logic        inv_coincident;
    logic [15:0] inv_addr_seen;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic resp_ready(input int p);
        return (p == 0) ? memory_response_ready_0 : memory_response_ready_1;
    endfunction

    function automatic logic [15:0] resp_data(input int p);
        return (p == 0) ? memory_response_0 : memory_response_1;
    endfunction

    function automatic logic inv_valid(input int p);
        return (p == 0) ? invalidate_valid_0 : invalidate_valid_1;
    endfunction

    function automatic logic [15:0] inv_addr(input int p);
        return (p == 0) ? invalidate_address_0 : invalidate_address_1;
    endfunction

    task automatic drive(input int p, input logic [32:0] req, input logic rdy);
        if (p == 0) begin
            memory_request_0       = req;
            memory_request_ready_0 = rdy;
        end else begin
            memory_request_1       = req;
            memory_request_ready_1 = rdy;
        end
    endtask

    // Called on a negedge; holds the request until its pulse, then drops it like a cache would.
    task automatic serve(input int p, input logic [32:0] req);
        bit seen;
        seen           = 1'b0;
        last_lat       = -1;
        last_data      = '0;
        last_width_ok  = 1'b0;
        other_pulses   = 0;
        inv_other_hits = 0;
        inv_self_hits  = 0;
        inv_coincident = 1'b0;
        inv_addr_seen  = '0;
        drive(p, req, 1'b1);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clock);
            if (resp_ready(1 - p)) other_pulses++;
            if (inv_valid(1 - p)) begin
                inv_other_hits++;
                inv_addr_seen = inv_addr(1 - p);
            end
            if (inv_valid(p)) inv_self_hits++;
            if (resp_ready(p)) begin
                seen           = 1'b1;
                last_lat       = n;
                last_data      = resp_data(p);
                inv_coincident = inv_valid(1 - p);
            end
        end
        if (seen) begin
            @(negedge clock);
            last_width_ok = !resp_ready(p);
            if (inv_valid(1 - p)) inv_other_hits++;
            if (inv_valid(p)) inv_self_hits++;
        end
        drive(p, req, 1'b0);
        @(negedge clock);
    endtask

    task automatic txn(input string tag, input int p, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data);
        logic [15:0] exp;
        int          idx;
        idx = int'(addr[AWB:1]);
        if (wr == WRITE) begin
            model_mem[idx] = data;
            written_idx.push_back(idx);
            exp = data;
        end else begin
            exp = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
        end
        serve(p, {wr, data, addr});
        check({tag, "_lat"}, 32'(last_lat), 32'(SINGLE_WAIT));
        check({tag, "_data"}, 32'(last_data), 32'(exp));
        check({tag, "_width"}, 32'(last_width_ok), 32'd1);
        check({tag, "_other_port"}, 32'(other_pulses), 32'd0);
`ifdef MEMORY_INVALIDATE_EN
        check({tag, "_inv_hits"}, 32'(inv_other_hits), (wr == WRITE) ? 32'd1 : 32'd0);
        check({tag, "_inv_self"}, 32'(inv_self_hits), 32'd0);
        if (wr == WRITE) begin
            check({tag, "_inv_coincident"}, 32'(inv_coincident), 32'd1);
            check({tag, "_inv_addr"}, 32'(inv_addr_seen), 32'(addr));
        end
`else
        check({tag, "_inv_tied"}, 32'(inv_other_hits + inv_self_hits), 32'd0);
`endif
    endtask

    // Both ports raise read requests together; the pointer model predicts who goes first.
    task automatic pair(input string tag, input logic [15:0] a0, input logic [15:0] a1);
        int          t0, t1, c0, c1;
        logic [15:0] d0, d1, e0, e1;
        t0 = -1; t1 = -1; c0 = 0; c1 = 0; d0 = '0; d1 = '0;
        e0 = model_mem[int'(a0[AWB:1])];
        e1 = model_mem[int'(a1[AWB:1])];
        drive(0, {READ, 16'h5A5A, a0}, 1'b1);
        drive(1, {READ, 16'hA5A5, a1}, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (memory_response_ready_0) begin
                c0++;
                if (t0 < 0) begin
                    t0 = n;
                    d0 = memory_response_0;
                end
            end
            if (memory_response_ready_1) begin
                c1++;
                if (t1 < 0) begin
                    t1 = n;
                    d1 = memory_response_1;
                end
            end
            if (t0 > 0 && n > t0) memory_request_ready_0 = 1'b0;
            if (t1 > 0 && n > t1) memory_request_ready_1 = 1'b0;
        end
        check({tag, "_count0"}, 32'(c0), 32'd1);
        check({tag, "_count1"}, 32'(c1), 32'd1);
        check({tag, "_data0"}, 32'(d0), 32'(e0));
        check({tag, "_data1"}, 32'(d1), 32'(e1));
        if (rr_ptr == 0) begin
            check({tag, "_first_t0"}, 32'(t0), 32'(SINGLE_WAIT));
            check({tag, "_second_t1"}, 32'(t1), 32'(SINGLE_WAIT + SLOT));
        end else begin
            check({tag, "_first_t1"}, 32'(t1), 32'(SINGLE_WAIT));
            check({tag, "_second_t0"}, 32'(t0), 32'(SINGLE_WAIT + SLOT));
        end
        rr_ptr = 1 - rr_ptr;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          held_pulses, first_seen, idx;
        logic        wr;
        logic [15:0] addr, data;
        int          port;

        reset = 1'b0;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        #12;
        check("reset_resp0", 32'(memory_response_0), 32'd0);
        check("reset_resp1", 32'(memory_response_1), 32'd0);
        check("reset_ready", 32'({memory_response_ready_0, memory_response_ready_1}), 32'd0);
        check("reset_inv", {invalidate_address_0, invalidate_address_1}, 32'd0);
        check("reset_inv_valid", 32'({invalidate_valid_0, invalidate_valid_1}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        txn("w0_beef", 0, WRITE, 16'h0010, 16'hBEEF);
        txn("r0_beef", 0, READ, 16'h0011, 16'h0000);
        check("r0_beef_const", 32'(last_data), 32'h0000BEEF);
        txn("w1_1234", 1, WRITE, 16'h0042, 16'h1234);

        pair("pair_a", 16'h0010, 16'h0042);
        @(negedge clock);
        pair("pair_b", 16'h0042, 16'h0010);
        @(negedge clock);

        // Port 0 keeps ready high well past its pulse: the request must not be served twice.
        drive(0, {READ, 16'h0000, 16'h0042}, 1'b1);
        first_seen = -1;
        for (int n = 1; n <= 40 && first_seen < 0; n++) begin
            @(negedge clock);
            if (memory_response_ready_0) first_seen = n;
        end
        check("hold_first_lat", 32'(first_seen), 32'(SINGLE_WAIT));
        held_pulses = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (memory_response_ready_0) held_pulses++;
        end
        check("hold_no_repeat", 32'(held_pulses), 32'd0);
        drive(0, '0, 1'b0);
        @(negedge clock);
        txn("hold_rearm", 0, READ, 16'h0042, 16'h0000);
        held_pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (memory_response_ready_0) held_pulses++;
        end
        check("rearm_single", 32'(held_pulses), 32'd0);

        // Reset during the access phase of a read.
        check("pre_reset_resp0", 32'(memory_response_0), 32'h00001234);
        drive(0, {READ, 16'h0000, 16'h0010}, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_resp0", 32'(memory_response_0), 32'd0);
        check("midrst_resp1", 32'(memory_response_1), 32'd0);
        check("midrst_ready", 32'({memory_response_ready_0, memory_response_ready_1}), 32'd0);
        check("midrst_inv", {invalidate_address_0, invalidate_address_1}, 32'd0);
        check("midrst_inv_valid", 32'({invalidate_valid_0, invalidate_valid_1}), 32'd0);
        drive(0, '0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        held_pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (memory_response_ready_0 || memory_response_ready_1) held_pulses++;
        end
        check("post_reset_quiet", 32'(held_pulses), 32'd0);
        txn("post_reset_read", 1, READ, 16'h0010, 16'h0000);

        txn("alias_w", 0, WRITE, 16'h0002, 16'hAAAA);
        txn("alias_r", 1, READ, 16'h0202, 16'h0000);
        check("alias_const", 32'(last_data), 32'h0000AAAA);

        for (int i = 0; i < 30; i++) begin
            port = int'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 1) == 1) ? WRITE : READ;
            data = 16'($urandom);
            if (wr == WRITE) begin
                addr = 16'($urandom);
            end else begin
                idx  = written_idx[$urandom_range(0, written_idx.size() - 1)];
                addr = {7'($urandom), 8'(idx), 1'($urandom)};
            end
            txn("rand", port, wr, addr, data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side end of the cache/memory request protocol.
- Accepts 33-bit memory requests from two cache instances: bit 32 r/w (0 read, 1 write), 31:16 data, 15:0 byte address.
- Arbitrates between the two ports round-robin and services each request from an internal 16-bit-word memory after a fixed latency.
- Returns a 16-bit word with a one-cycle ready pulse and reports write addresses to the other cache for invalidation.

Parameters:
- ADDR_WORD_BITS, 8: word-index width; memory depth is 2**ADDR_WORD_BITS words of 16 bits.
- ACCESS_LATENCY, 2: cycles spent in ACCESS before the response, range 1..15.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- memory_request_0  input  33  request from cache 0.
- memory_request_ready_0  input  1  request 0 valid; held high until served.
- memory_request_1  input  33  request from cache 1.
- memory_request_ready_1  input  1  request 1 valid.
- memory_response_0  output  16  data word to cache 0.
- memory_response_ready_0  output  1  one-cycle pulse; memory_response_0 valid.
- memory_response_1  output  16  data word to cache 1.
- memory_response_ready_1  output  1  one-cycle pulse for port 1.
- invalidate_address_0  output  16  address cache 0 must invalidate.
- invalidate_valid_0  output  1  one-cycle strobe qualifying invalidate_address_0.
- invalidate_address_1  output  16  address cache 1 must invalidate.
- invalidate_valid_1  output  1  one-cycle strobe for port 1.

Behaviour:
- Reset, while reset is low, asynchronously forces:
  - all response, ready, invalidate and strobe outputs to 0;
  - FSM to IDLE, round-robin pointer to port 0, latency counter to 0, both release flags clear.
  - Memory array contents are not reset.
- Reset mid-operation abandons the transaction with no response and no write. Exception: a write already committed on ACCESS entry stays committed.
- Word index is address[ADDR_WORD_BITS:1]. Address bit 0 is ignored because the response is always the full word. Address bits above the index alias.
- FSM states: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE:
  - A port is eligible when its request_ready is high and its release flag is clear.
  - If one port is eligible, grant it. If both are eligible, grant the port the pointer names, then toggle the pointer to the other port.
  - On grant: capture the 33-bit request into a holding register, load the counter with ACCESS_LATENCY-1, go to ACCESS.
- ACCESS:
  - Write: on the entry cycle, store data into the array at the index. Capture the full 16-bit address for invalidation.
  - Read: the array read uses the captured index.
  - Decrement the counter each cycle; at 0 go to RESPOND. Total request-to-pulse latency is ACCESS_LATENCY+1 cycles.
- RESPOND:
  - Drive the granted port's response with the read data, or the written data for a write, so the cache can fill its line.
  - Pulse that port's response_ready for exactly one cycle. Set that port's release flag. Go to RELEASE.
  - The other port's response outputs hold their previous value, ready stays 0.
- RELEASE: go to IDLE the next cycle.
- Release flag clears when that port's request_ready is sampled low. The cache drops ready a cycle or more after the pulse, so a stale held request is never served twice.
- Response data stays on the bus until the next response to that port.
- Invalidate:
  - A write from port N drives invalidate_address of the other port with the write address and strobes its invalidate_valid once, in the same cycle as the RESPOND pulse.
  - The writer is never invalidated.
- Requests arriving while busy are not dropped. The cache holds ready, and the request is served on the next IDLE.
- Back-to-back: port 1 waiting while port 0 is served is granted on the first IDLE after RELEASE.

Optional Feature:
- Macro MEMORY_INVALIDATE_EN.
- Defined: invalidate broadcast exactly as above.
- Undefined: no invalidate logic is built; invalidate_address_* and invalidate_valid_* are tied to 0.
- Read/write data path and timing are identical in both builds.

Decomposition:
- Package memory_pkg:
  - request field ranges: RW bit 32, DATA 31:16, ADDR 15:0;
  - READ=0 and WRITE=1 constants;
  - FSM state encoding (2 bits).
- Sub-module memory_arbiter: 2-input round-robin grant with pointer register and the two release flags. Outputs grant_valid and grant_port.

Test Plan:
- Write port 0 {1, 16'hBEEF, 16'h0010}, then read port 0 addr 16'h0011 -> both responses 16'hBEEF; ready pulses 3 cycles after each grant, one cycle wide.
- Both ports request reads of the same cycle after reset -> port 0 served first, port 1 served immediately after RELEASE. Next simultaneous pair -> port 1 first.
- With MEMORY_INVALIDATE_EN: port 1 writes 16'h1234 to 16'h0042 -> invalidate_address_0=16'h0042, invalidate_valid_0 high one cycle, coincident with memory_response_ready_1. Port 1 invalidate outputs stay 0.
- Port 0 holds request_ready high 5 cycles after its response pulse -> no second response. After ready drops and a new request arrives, exactly one response.
- Assert reset low during ACCESS of a read -> all outputs 0 immediately. After release, no response pulse until a fresh request.
- ADDR_WORD_BITS=8: write 16'hAAAA at 16'h0002, read 16'h0202 -> 16'hAAAA (alias confirmed).
